// File: rtl/stream_throttle_pkg.sv
// stream_throttle_pkg: shared mode encodings, LFSR constants and seed helpers.
package stream_throttle_pkg;

  typedef enum logic [1:0] {
    MODE_BURST  = 2'd0,
    MODE_DUTY   = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_FALLBACK = 16'hACE1;
  localparam logic [15:0] SEED_STRIDE   = 16'h9E37;

  // Per-lane seed; an all-zero LFSR would lock up, so it falls back to a known value.
  function automatic logic [15:0] lane_seed(input logic [15:0] seed, input int unsigned lane);
    logic [15:0] s;
    s = seed ^ (16'(lane) * SEED_STRIDE);
    return (s == 16'h0000) ? SEED_FALLBACK : s;
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ ({16{s[0]}} & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/stream_throttle_lane.sv
// stream_throttle_lane: one lane of the shaper -- 2-entry skid buffer, valid gate
// with hold latch, per-lane LFSR and beat counter.
// Optional stall counter enabled by STREAM_THROTTLE_STALL_CNT_EN.
module stream_throttle_lane
  import stream_throttle_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned CW        = 16,
  parameter logic [15:0] SEED_INIT = 16'hACE1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  mode_e            iMode,
  input  logic             iDutyOpen,
  input  logic [7:0]       iThresh,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic [CW-1:0]    oCount
`ifdef STREAM_THROTTLE_STALL_CNT_EN
  ,
  output logic [CW-1:0]    oStall
`endif
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       entries_q, entries_d;
  logic             ready_q, ready_d;
  logic             held_q, held_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             gate_open;
  logic             valid_c;
  logic             in_xfer;
  logic             out_xfer;
  logic             wr_ptr;

  // Gate selection for the current mode.
  always_comb begin
    gate_open = 1'b0;
    case (iMode)
      MODE_BURST:  gate_open = 1'b1;
      MODE_DUTY:   gate_open = iDutyOpen;
      MODE_RANDOM: gate_open = (lfsr_q[7:0] >= iThresh);
      MODE_HOLD:   gate_open = 1'b0;
      default:     gate_open = 1'b0;
    endcase
  end

  // Next-state for buffer, hold latch, LFSR and beat counter.
  always_comb begin
    valid_c   = (entries_q != 2'd0) & (gate_open | held_q);
    in_xfer   = iValid & ready_q;
    out_xfer  = valid_c & iReady;
    wr_ptr    = rd_ptr_q ^ entries_q[0];
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q ^ out_xfer;
    entries_d = entries_q;
    held_d    = held_q;
    lfsr_d    = lfsr_q;
    count_d   = count_q;

    if (in_xfer) mem_d[wr_ptr] = iData;

    case ({in_xfer, out_xfer})
      2'b10:   entries_d = entries_q + 2'd1;
      2'b01:   entries_d = entries_q - 2'd1;
      default: entries_d = entries_q;
    endcase
    ready_d = (entries_d != 2'd2);

    // A presented beat stays presented until it transfers.
    if (out_xfer)                held_d = 1'b0;
    else if (valid_c && !iReady) held_d = 1'b1;

    if (iMode == MODE_RANDOM) lfsr_d = lfsr_step(lfsr_q);

    if (out_xfer && (count_q != {CW{1'b1}})) count_d = count_q + CW'(1);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      rd_ptr_q  <= 1'b0;
      entries_q <= 2'd0;
      ready_q   <= 1'b0;
      held_q    <= 1'b0;
      lfsr_q    <= SEED_INIT;
      count_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      entries_q <= entries_d;
      ready_q   <= ready_d;
      held_q    <= held_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
    end
  end

  // Buffer storage; contents are don't-care while empty.
  always_ff @(posedge iCLK) begin
    mem_q <= mem_d;
  end

`ifdef STREAM_THROTTLE_STALL_CNT_EN
  logic [CW-1:0] stall_q, stall_d;

  // Saturating count of cycles with a presented but unaccepted beat.
  always_comb begin
    stall_d = stall_q;
    if (valid_c && !iReady && (stall_q != {CW{1'b1}})) stall_d = stall_q + CW'(1);
  end

  // Stall counter register.
  always_ff @(posedge iCLK) begin
    if (!iRST) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign oStall = stall_q;
`endif

  assign oReady = ready_q;
  assign oValid = valid_c;
  assign oData  = mem_q[rd_ptr_q];
  assign oCount = count_q;

endmodule

// File: rtl/stream_throttle.sv
// stream_throttle: multi-lane valid/ready traffic shaper (burst/duty/random/hold).
// Optional per-lane stall counters enabled by STREAM_THROTTLE_STALL_CNT_EN.
module stream_throttle
  import stream_throttle_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned PERIOD = 8,
  parameter int unsigned CW     = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [1:0]                iMode,
  input  logic [$clog2(PERIOD):0]   iGap,
  input  logic [7:0]                iThresh,
  input  logic [NCH-1:0]            iValid_AM,
  output logic [NCH-1:0]            oReady_AM,
  input  logic [NCH*WIDTH-1:0]      iData_AM,
  output logic [NCH-1:0]            oValid_BM,
  input  logic [NCH-1:0]            iReady_BM,
  output logic [NCH*WIDTH-1:0]      oData_BM,
  output logic [NCH*CW-1:0]         oCount
`ifdef STREAM_THROTTLE_STALL_CNT_EN
  ,
  output logic [NCH*CW-1:0]         oStall
`endif
);

  localparam int unsigned DCW = $clog2(PERIOD);
  localparam int unsigned GW  = DCW + 1;

  logic [DCW-1:0] duty_q, duty_d;
  logic           duty_open;

  // Shared free-running duty counter, wraps at PERIOD-1.
  always_comb begin
    duty_d    = (duty_q == DCW'(PERIOD - 1)) ? '0 : duty_q + DCW'(1);
    duty_open = (GW'(duty_q) >= iGap);
  end

  // Duty counter register.
  always_ff @(posedge iCLK) begin
    if (!iRST) duty_q <= '0;
    else       duty_q <= duty_d;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    stream_throttle_lane #(
      .WIDTH     (WIDTH),
      .CW        (CW),
      .SEED_INIT (lane_seed(SEED, k))
    ) u_lane (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iMode     (mode_e'(iMode)),
      .iDutyOpen (duty_open),
      .iThresh   (iThresh),
      .iValid    (iValid_AM[k]),
      .oReady    (oReady_AM[k]),
      .iData     (iData_AM[k*WIDTH +: WIDTH]),
      .oValid    (oValid_BM[k]),
      .iReady    (iReady_BM[k]),
      .oData     (oData_BM[k*WIDTH +: WIDTH]),
      .oCount    (oCount[k*CW +: CW])
`ifdef STREAM_THROTTLE_STALL_CNT_EN
      ,
      .oStall    (oStall[k*CW +: CW])
`endif
    );
  end

endmodule
